// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, branch, MUL/DIV and memory-wait hazards.
// Optional stall performance counter: define PIPELINE_STALL_CTRL_PERF_CNT_EN.
module pipeline_stall_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             LoadE,
  input  logic [4:0]       RD_E,
  input  logic [4:0]       Rs1_D,
  input  logic [4:0]       Rs2_D,
  input  logic             PCSrcE,
  input  logic             MulOpE,
  input  logic             MulDone,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic             MulStart,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic             FlushW,
  output logic             MemErr
`ifdef PIPELINE_STALL_CTRL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] StallCnt
`endif
);

  localparam int unsigned WD_W = $clog2(MEM_TIMEOUT + 1);

  if (MEM_TIMEOUT < 2) begin : g_bad_timeout
    $error("pipeline_stall_ctrl: MEM_TIMEOUT must be >= 2");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("pipeline_stall_ctrl: CNT_W must be >= 1");
  end

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MC_WAIT  = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  state_t          r_state;
  logic [WD_W-1:0] r_wd;
  logic            r_memerr;

  logic w_memwait;
  logic w_loaduse;
  logic w_wd_expired;

  assign w_memwait    = MemReqM & ~MemReadyM & ~r_memerr;
  assign w_loaduse    = LoadE & (RD_E != 5'd0) & ((RD_E == Rs1_D) | (RD_E == Rs2_D));
  assign w_wd_expired = (r_wd == WD_W'(MEM_TIMEOUT - 1));
  assign MemErr       = r_memerr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= RUN;
      r_wd     <= '0;
      r_memerr <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_memwait) begin
            r_state <= MEM_WAIT;
            r_wd    <= '0;
          end else if (MulOpE) begin
            r_state <= MC_WAIT;
          end
        end
        MC_WAIT: begin
          if (MulDone) r_state <= RUN;
        end
        MEM_WAIT: begin
          if (MemReadyM) begin
            r_state <= RUN;
          end else if (w_wd_expired) begin
            r_memerr <= 1'b1;
            r_state  <= RUN;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

  // Controls are combinational off the registered state; forcing them low while
  // rst is high keeps MulStart and the stalls quiet even with MulOpE asserted.
  always_comb begin
    MulStart = 1'b0;
    StallF   = 1'b0;
    StallD   = 1'b0;
    StallE   = 1'b0;
    StallM   = 1'b0;
    FlushD   = 1'b0;
    FlushE   = 1'b0;
    FlushM   = 1'b0;
    FlushW   = 1'b0;
    if (!rst) begin
      case (r_state)
        RUN: begin
          if (w_memwait) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
          end else if (MulOpE) begin
            MulStart = 1'b1;
            StallF   = 1'b1;
            StallD   = 1'b1;
            StallE   = 1'b1;
            FlushM   = 1'b1;
          end else if (PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
          end else if (w_loaduse) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
          end
        end
        MC_WAIT: begin
          if (!MulDone) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            FlushM = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (!MemReadyM) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef PIPELINE_STALL_CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (StallF && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign StallCnt = r_stall_cnt;
`endif

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RISC-V pipeline. It sits beside the forwarding/hazard unit and combines four hazard sources into per-stage stall and flush controls:
- load-use in Decode
- taken branch in Execute
- multi-cycle MUL/DIV in Execute
- data-memory wait in Memory

It owns the start/done handshake to the multi-cycle unit and a watchdog on memory waits.

Parameters:
MEM_TIMEOUT, 16, max cycles spent in MEM_WAIT before forced release (>=2)
CNT_W, 16, width of the stall performance counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
LoadE  in  1  instruction in E is a load
RD_E  in  5  destination register of the instruction in E
Rs1_D  in  5  source register 1 of the instruction in D
Rs2_D  in  5  source register 2 of the instruction in D
PCSrcE  in  1  taken branch/jump resolved in E
MulOpE  in  1  instruction in E needs the multi-cycle unit
MulDone  in  1  multi-cycle unit result valid (1-cycle pulse)
MemReqM  in  1  instruction in M accesses data memory
MemReadyM  in  1  data memory completes access this cycle
MulStart  out  1  1-cycle start pulse to the multi-cycle unit
StallF, StallD, StallE, StallM  out  1 each  hold the stage register
FlushD, FlushE, FlushM, FlushW  out  1 each  insert a bubble into the stage register
MemErr  out  1  sticky: memory watchdog expired
StallCnt  out  CNT_W  (PERF_CNT_EN only) cycles with StallF=1

Behaviour:
- FSM states: RUN, MC_WAIT, MEM_WAIT. Registered state.
- Reset values (async): RUN; MulStart=0; MemErr=0; watchdog=0; StallCnt=0. Stall/flush outputs are combinational and evaluate to 0 in RUN with all inputs 0.
- Reset mid-operation returns to RUN immediately. MulStart never glitches high during reset.
- memwait = MemReqM & !MemReadyM & !MemErr.
- RUN, priority high to low:
  - memwait: StallF=StallD=StallE=StallM=1, FlushW=1; next state MEM_WAIT, watchdog cleared.
  - MulOpE: MulStart=1, StallF=StallD=StallE=1, FlushM=1; next state MC_WAIT.
  - PCSrcE: FlushD=FlushE=1, no stall. Branch overrides load-use.
  - Load-use (LoadE & RD_E!=0 & (RD_E==Rs1_D | RD_E==Rs2_D)): StallF=StallD=1, FlushE=1 for that cycle only.
- MC_WAIT:
  - MulDone=0: StallF=StallD=StallE=1, FlushM=1.
  - MulDone=1: all outputs 0 that cycle (result advances E->M); next state RUN.
  - MulStart stays 0 in MC_WAIT.
  - A MulDone outside MC_WAIT is ignored.
- MEM_WAIT:
  - MemReadyM=0: StallF..StallM=1, FlushW=1; watchdog increments.
  - MemReadyM=1: all outputs 0 that cycle; next state RUN.
  - Watchdog: when the watchdog reaches MEM_TIMEOUT-1 with MemReadyM=0, set MemErr=1 on the next edge and move to RUN. That cycle still stalls, so the stall lasts exactly MEM_TIMEOUT cycles in MEM_WAIT.
  - MemErr stays set until reset and masks memwait, so the pipeline keeps moving.
- Simultaneous events:
  - memwait with MulOpE in RUN: memory wins; MulStart is deferred until the pipeline returns to RUN with MulOpE still high.
  - PCSrcE with load-use: flush only.
- Watchdog width is clog2(MEM_TIMEOUT+1).

Optional Feature:
PIPELINE_STALL_CTRL_PERF_CNT_EN
- Defined: StallCnt port exists. It increments by 1 on each edge where StallF=1, saturates at all-ones, and resets to 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Load-use: LoadE=1, RD_E=5, Rs1_D=5, one cycle -> StallF=StallD=FlushE=1 for 1 cycle. Repeat with RD_E=0 -> all outputs 0.
- Branch over load-use: PCSrcE=1 with the same load-use inputs -> FlushD=FlushE=1, StallF=0, StallD=0.
- Multi-cycle op: MulOpE=1 at cycle 0, MulDone at cycle 4 -> MulStart pulse at cycle 0 only; StallF/D/E and FlushM high cycles 0-3, low at cycle 4; state RUN at cycle 5.
- Memory wait: MemReqM=1, MemReadyM low 3 cycles then high -> StallF..StallM and FlushW high 3 cycles, low in the ready cycle; MemErr=0.
- Watchdog with MEM_TIMEOUT=4: MemReadyM held 0 -> stalls for entry cycle + 4 MEM_WAIT cycles, then MemErr=1, stalls 0, and stay 0 while MemReqM stays 1.
- Reset during MC_WAIT: assert rst at cycle 2 of a MUL -> state RUN and outputs 0 immediately. With PIPELINE_STALL_CTRL_PERF_CNT_EN defined, StallCnt=0; after 3 load-use stalls, StallCnt=3.
